// File: rtl/gray_counter_src.sv
// rtl/gray_counter_src.sv - up/down counter with registered Gray output; define GRAY_SAT_EN to saturate instead of wrap
module gray_counter_src #(
    parameter int NUM  = 6,
    parameter int INIT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic           up_dn,
    input  logic           load,
    input  logic [NUM-1:0] load_gray,
    output logic [NUM-1:0] g_out,
    output logic           tc
);

    localparam logic [NUM-1:0] INIT_B = INIT[NUM-1:0];
    localparam logic [NUM-1:0] MAXV   = {NUM{1'b1}};
    localparam logic [NUM-1:0] ONE    = {{(NUM-1){1'b0}}, 1'b1};

    logic [NUM-1:0] bcnt;
    logic [NUM-1:0] bcnt_nx;
    logic [NUM-1:0] g_nx;
    logic           tc_nx;

    function automatic logic [NUM-1:0] bin2gray(input logic [NUM-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the running XOR of all Gray bits from the MSB down.
    function automatic logic [NUM-1:0] gray2bin(input logic [NUM-1:0] g);
        logic [NUM-1:0] b;
        b[NUM-1] = g[NUM-1];
        for (int i = NUM - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next count: clr beats load beats en; dropped requests are not remembered.
    always_comb begin
        bcnt_nx = bcnt;
        g_nx    = g_out;
        tc_nx   = 1'b0;
        if (clr) begin
            bcnt_nx = '0;
            g_nx    = '0;
        end else if (load) begin
            bcnt_nx = gray2bin(load_gray);
            g_nx    = load_gray;
        end else if (en) begin
            if (up_dn) begin
                if (bcnt == MAXV) begin
                    tc_nx = 1'b1;
`ifdef GRAY_SAT_EN
                    bcnt_nx = bcnt;
`else
                    bcnt_nx = '0;
`endif
                end else begin
                    bcnt_nx = bcnt + ONE;
                end
            end else begin
                if (bcnt == '0) begin
                    tc_nx = 1'b1;
`ifdef GRAY_SAT_EN
                    bcnt_nx = bcnt;
`else
                    bcnt_nx = MAXV;
`endif
                end else begin
                    bcnt_nx = bcnt - ONE;
                end
            end
            g_nx = bin2gray(bcnt_nx);
        end
    end

    // Register binary count, Gray output and terminal-count pulse together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= INIT_B;
            g_out <= bin2gray(INIT_B);
            tc    <= 1'b0;
        end else begin
            bcnt  <= bcnt_nx;
            g_out <= g_nx;
            tc    <= tc_nx;
        end
    end

endmodule

// File: tb/tb_gray_counter_src.sv
// tb/tb_gray_counter_src.sv - self-checking bench for gray_counter_src
module tb_gray_counter_src;

    localparam int NUM  = 6;
    localparam int INIT = 0;
    localparam int MOD  = 1 << NUM;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic           en = 1'b0;
    logic           up_dn = 1'b0;
    logic           load = 1'b0;
    logic [NUM-1:0] load_gray = '0;
    logic [NUM-1:0] g_out;
    logic           tc;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b0;

    int m_cnt;
    bit m_tc;

    gray_counter_src #(.NUM(NUM), .INIT(INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_gray (load_gray),
        .g_out     (g_out),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) % MOD;
    endfunction

    // Decode by search: the value whose Gray code matches.
    function automatic int val_of(input int g);
        for (int v = 0; v < MOD; v++) begin
            if (gray_of(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: integer count following the documented rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= INIT;
            m_tc  <= 1'b0;
        end else if (clr) begin
            m_cnt <= 0;
            m_tc  <= 1'b0;
        end else if (load) begin
            m_cnt <= val_of(int'(load_gray));
            m_tc  <= 1'b0;
        end else if (en) begin
            if (up_dn && m_cnt == MOD - 1) begin
                m_tc <= 1'b1;
`ifdef GRAY_SAT_EN
                m_cnt <= m_cnt;
`else
                m_cnt <= 0;
`endif
            end else if (!up_dn && m_cnt == 0) begin
                m_tc <= 1'b1;
`ifdef GRAY_SAT_EN
                m_cnt <= m_cnt;
`else
                m_cnt <= MOD - 1;
`endif
            end else begin
                m_cnt <= up_dn ? m_cnt + 1 : m_cnt - 1;
                m_tc  <= 1'b0;
            end
        end else begin
            m_tc <= 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_g_out", int'(g_out), gray_of(m_cnt));
            chk("model_tc", int'(tc), int'(m_tc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM-1:0] prev;
        #12;
        rst_n = 1'b1;
        cmp_on = 1'b1;
        #1;
        chk("reset_g_out", int'(g_out), 0);
        chk("reset_tc", int'(tc), 0);

        // 1: async reset mid-count
        en = 1'b1; up_dn = 1'b1;
        repeat (3) tick();
        chk("pre_reset_g", int'(g_out), 6'b000010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_g", int'(g_out), 0);
        chk("async_reset_tc", int'(tc), 0);
        repeat (3) tick();
        chk("reset_hold_g", int'(g_out), 0);
        en = 1'b0;
        rst_n = 1'b1;
        tick();

        // 2: full up count with wrap
        en = 1'b1; up_dn = 1'b1;
        prev = g_out;
        for (int k = 1; k <= MOD; k++) begin
            tick();
            chk("step_hamming", $countones(g_out ^ prev), 1);
`ifndef GRAY_SAT_EN
            chk("step_value", val_of(int'(g_out)), k % MOD);
            chk("step_tc", int'(tc), (k == MOD) ? 1 : 0);
            if (k == 1) chk("step1_g", int'(g_out), 6'b000001);
            if (k == 2) chk("step2_g", int'(g_out), 6'b000011);
            if (k == 3) chk("step3_g", int'(g_out), 6'b000010);
            if (k == MOD - 1) chk("step63_g", int'(g_out), 6'b100000);
            if (k == MOD) chk("step64_g", int'(g_out), 6'b000000);
`endif
            prev = g_out;
            if (k == MOD - 1) break;
        end
`ifndef GRAY_SAT_EN
        tick();
        chk("wrap_hamming", $countones(g_out ^ prev), 1);
        chk("wrap_g", int'(g_out), 6'b000000);
        chk("wrap_tc", int'(tc), 1);
        en = 1'b0;
        tick();
        chk("wrap_tc_clears", int'(tc), 0);

        // 3: down wrap from 0
        en = 1'b1; up_dn = 1'b0;
        tick();
        chk("down_wrap_g", int'(g_out), 6'b100000);
        chk("down_wrap_tc", int'(tc), 1);
        tick();
        chk("down_next_g", int'(g_out), 6'b100001);
        chk("down_next_tc", int'(tc), 0);
`endif
        en = 1'b0;

        // 4: load then step
        load = 1'b1; load_gray = 6'b110101;
        tick();
        load = 1'b0;
        chk("load_g", int'(g_out), 6'b110101);
        chk("load_val", val_of(int'(g_out)), 38);
        en = 1'b1; up_dn = 1'b1;
        tick();
        chk("load_step_g", int'(g_out), 6'b110100);
        en = 1'b0;

        // 5: priority clr > load > en
        load = 1'b1; load_gray = 6'b011001;
        tick();
        chk("load17_val", val_of(int'(g_out)), 17);
        clr = 1'b1; load = 1'b1; en = 1'b1; load_gray = 6'b110101;
        tick();
        chk("prio_clr_g", int'(g_out), 0);
        chk("prio_clr_tc", int'(tc), 0);
        clr = 1'b0;
        tick();
        chk("prio_load_g", int'(g_out), 6'b110101);
        load = 1'b0; en = 1'b0;

`ifdef GRAY_SAT_EN
        // 6: saturation at both ends
        load = 1'b1; load_gray = 6'b100000;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("sat_up_g", int'(g_out), 6'b100000);
        chk("sat_up_tc", int'(tc), 1);
        en = 1'b0;
        tick();
        chk("sat_up_tc_clears", int'(tc), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        chk("sat_dn_g", int'(g_out), 6'b000000);
        chk("sat_dn_tc", int'(tc), 1);
        en = 1'b0;
`endif

        // Mixed direction/enable pattern checked against the model.
        for (int i = 0; i < 48; i++) begin
            en    = (i % 3) != 0;
            up_dn = ((i / 4) % 2) == 0;
            clr   = (i == 30);
            load  = (i == 20);
            load_gray = 6'b000001;
            tick();
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        @(negedge clk);
        #1;
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
